// File: rtl/uart_sdram_bridge.sv
// UART command parser that issues single-word SDRAM read/write requests
// and returns the read data or a status byte over the serial link.
module uart_sdram_bridge #(
    parameter int REQ_TIMEOUT = 1024,
    parameter int RX_TIMEOUT  = 1000000
) (
    input  logic        clk_100MHz,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [23:0] addr,
    output logic        rd_req,
    output logic        wr_req,
    output logic [15:0] wr_data,
    input  logic [15:0] rd_data,
    input  logic        rd_valid,
    input  logic        wr_ready,
    output logic        busy,
    output logic        rx_overrun
);
    localparam int RQW = $clog2(REQ_TIMEOUT + 1);
    localparam int RXW = $clog2(RX_TIMEOUT + 1);
    localparam logic [RQW-1:0] REQ_LAST = RQW'(REQ_TIMEOUT - 1);
    localparam logic [RXW-1:0] RX_LAST  = RXW'(RX_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, ISSUE, WAIT, SEND} state_t;

    state_t          state_q;
    logic            is_wr_q;
    logic [1:0]      cnt_q;
    logic [RQW-1:0]  req_tmr_q;
    logic [RXW-1:0]  gap_q;
    logic [15:0]     resp_q;
    logic [1:0]      left_q;
    logic            hold_q;
    logic [23:0]     addr_q;
    logic [15:0]     wr_data_q;
    logic            rd_req_q, wr_req_q, tx_start_q, ovr_q;
    logic [7:0]      tx_data_q;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            is_wr_q    <= 1'b0;
            cnt_q      <= '0;
            req_tmr_q  <= '0;
            gap_q      <= '0;
            resp_q     <= '0;
            left_q     <= '0;
            hold_q     <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            ovr_q      <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_valid && (rx_data == 8'h57 || rx_data == 8'h52)) begin
                        is_wr_q <= (rx_data == 8'h57);
                        cnt_q   <= '0;
                        gap_q   <= '0;
                        state_q <= GET_ADDR;
                    end
                end
                GET_ADDR, GET_DATA: begin
                    if (rx_valid) begin
                        gap_q <= '0;
                        cnt_q <= cnt_q + 2'd1;
                        if (state_q == GET_ADDR) begin
                            addr_q <= {addr_q[15:0], rx_data};
                            if (cnt_q == 2'd2) begin
                                cnt_q <= '0;
                                if (is_wr_q) begin
                                    state_q <= GET_DATA;
                                end else begin
                                    rd_req_q  <= 1'b1;
                                    req_tmr_q <= '0;
                                    state_q   <= ISSUE;
                                end
                            end
                        end else begin
                            wr_data_q <= {wr_data_q[7:0], rx_data};
                            if (cnt_q == 2'd1) begin
                                wr_req_q  <= 1'b1;
                                req_tmr_q <= '0;
                                state_q   <= ISSUE;
                            end
                        end
                    end else if (gap_q == RX_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                ISSUE: begin
                    req_tmr_q <= req_tmr_q + 1'b1;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    // Completion is checked first so it beats a same-cycle timeout.
                    if (is_wr_q ? wr_ready : rd_valid) begin
                        rd_req_q <= 1'b0;
                        wr_req_q <= 1'b0;
                        resp_q   <= is_wr_q ? 16'h004B : rd_data;
                        left_q   <= is_wr_q ? 2'd1 : 2'd2;
                        hold_q   <= 1'b0;
                        state_q  <= SEND;
                    end else if (req_tmr_q == REQ_LAST) begin
                        rd_req_q <= 1'b0;
                        wr_req_q <= 1'b0;
                        resp_q   <= 16'h0045;
                        left_q   <= 2'd1;
                        hold_q   <= 1'b0;
                        state_q  <= SEND;
                    end else begin
                        req_tmr_q <= req_tmr_q + 1'b1;
                    end
                end
                SEND: begin
                    // hold_q skips the cycle where tx_busy has not yet risen.
                    if (hold_q) begin
                        hold_q <= 1'b0;
                    end else if (!tx_busy) begin
                        if (left_q != 2'd0) begin
                            tx_start_q <= 1'b1;
                            tx_data_q  <= (left_q == 2'd2) ? resp_q[15:8] : resp_q[7:0];
                            left_q     <= left_q - 2'd1;
                            hold_q     <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (rx_valid && (state_q == ISSUE || state_q == WAIT || state_q == SEND))
                ovr_q <= 1'b1;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign addr       = addr_q;
    assign rd_req     = rd_req_q;
    assign wr_req     = wr_req_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q != IDLE);
    assign rx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_sdram_bridge.sv
// Scoreboard bench for uart_sdram_bridge: SDRAM responder and UART tx models
// pop expected requests/bytes pushed by the stimulus thread.
module tb_uart_sdram_bridge;
  localparam int REQ_TIMEOUT = 40;
  localparam int RX_TIMEOUT  = 60;
  localparam int TX_LEN      = 8;

  typedef struct { logic rd; logic [23:0] a; logic [15:0] d; } req_t;

  logic        clk, rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start, tx_busy;
  logic [23:0] addr;
  logic        rd_req, wr_req;
  logic [15:0] wr_data, rd_data;
  logic        rd_valid, wr_ready, busy, rx_overrun;

  req_t        reqq[$];
  logic [7:0]  txq[$];
  int          n_vec = 0, n_err = 0;
  int          rsp_mode = 0;   // 0 normal, 1 never respond (timeout), 2 never respond (reset)
  int          rsp_lat  = 4;
  logic [15:0] rsp_data = 16'h0;

  uart_sdram_bridge #(.REQ_TIMEOUT(REQ_TIMEOUT), .RX_TIMEOUT(RX_TIMEOUT)) dut (
    .clk_100MHz(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .addr(addr),
    .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_ready(wr_ready), .busy(busy), .rx_overrun(rx_overrun)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rd_req && wr_req) chk("req_excl", 1, 0);

  // SDRAM controller model
  logic        r_rd, r_held;
  logic [23:0] r_a;
  logic [15:0] r_d;
  int          r_n;
  initial begin
    rd_valid = 0; wr_ready = 0; rd_data = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (rd_req || wr_req) begin
        r_rd = rd_req; r_a = addr; r_d = wr_data; r_held = 1;
        if (reqq.size() == 0) chk("req_unexp", 1, 0);
        else begin
          req_t e;
          e = reqq.pop_front();
          chk("req_kind", r_rd, e.rd);
          chk("req_addr", addr, e.a);
          if (!e.rd) chk("req_wdata", wr_data, e.d);
        end
        if (rsp_mode == 0) begin
          for (int k = 1; k <= rsp_lat; k++) begin
            @(posedge clk); #1;
            if (!(r_rd ? rd_req : wr_req) || addr !== r_a || wr_data !== r_d) r_held = 0;
          end
          if (r_rd) begin rd_data = rsp_data; rd_valid = 1; end
          else wr_ready = 1;
          @(posedge clk); #1;
          rd_valid = 0; wr_ready = 0; rd_data = 16'hDEAD;
          chk("req_held", r_held, 1);
          chk("req_drop", rd_req | wr_req, 0);
        end else begin
          r_n = 1;
          while ((rd_req || wr_req) && r_n < 4 * REQ_TIMEOUT) begin
            @(negedge clk);
            if (rd_req || wr_req) begin
              r_n++;
              if (addr !== r_a || wr_data !== r_d) r_held = 0;
            end
          end
          if (rsp_mode == 1) begin
            chk("tmo_len", r_n, REQ_TIMEOUT);
            chk("tmo_held", r_held, 1);
          end
        end
      end
    end
  end

  // UART transmitter model
  logic [7:0] t_b;
  logic       t_ok;
  initial begin
    tx_busy = 0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (txq.size() == 0) chk("tx_unexp", {24'h0, tx_data}, 32'hFFFF);
        else chk("tx_byte", tx_data, txq.pop_front());
        t_b = tx_data; t_ok = 1;
        @(posedge clk); #1 tx_busy = 1;
        repeat (TX_LEN) begin
          @(negedge clk);
          if (tx_start || tx_data !== t_b) t_ok = 0;
        end
        tx_busy = 0;
        chk("tx_hold", t_ok, 1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1;
    @(negedge clk); rx_valid = 0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmd_wr(input logic [23:0] a, input logic [15:0] d, input int g);
    req_t e;
    e.rd = 0; e.a = a; e.d = d;
    reqq.push_back(e);
    send_byte(8'h57);
    send_byte(a[23:16]); gap(g); send_byte(a[15:8]); gap(g); send_byte(a[7:0]);
    send_byte(d[15:8]); gap(g); send_byte(d[7:0]);
    chk("wr_req_lat", wr_req, 1);
  endtask

  task automatic cmd_rd(input logic [23:0] a);
    req_t e;
    e.rd = 1; e.a = a; e.d = 16'h0;
    reqq.push_back(e);
    send_byte(8'h52);
    send_byte(a[23:16]); send_byte(a[15:8]); send_byte(a[7:0]);
    chk("rd_req_lat", rd_req, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || tx_busy) && n < 400) begin @(negedge clk); n++; end
    chk(tag, busy, 0);
    chk("txq_empty", txq.size(), 0);
    chk("reqq_empty", reqq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 0; rx_valid = 0; rx_data = 0;
    gap(3);
    chk("rst_out", {tx_start, rd_req, wr_req, busy, rx_overrun}, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wr_data", wr_data, 0);
    rst_n = 1;
    gap(2);

    // write
    rsp_mode = 0; rsp_lat = 4;
    txq.push_back(8'h4B);
    cmd_wr(24'h123456, 16'hABCD, 0);
    wait_idle("wr_idle");

    // read
    rsp_lat = 5; rsp_data = 16'hBEEF;
    txq.push_back(8'hBE); txq.push_back(8'hEF);
    cmd_rd(24'h0001FF);
    wait_idle("rd_idle");

    // bad opcode then read
    send_byte(8'h00);
    gap(3);
    chk("badop_idle", busy, 0);
    rsp_lat = 2; rsp_data = 16'h1234;
    txq.push_back(8'h12); txq.push_back(8'h34);
    cmd_rd(24'h000001);
    wait_idle("badop_rd_idle");

    // request timeout
    rsp_mode = 1;
    txq.push_back(8'h45);
    cmd_rd(24'h0ABCDE);
    wait_idle("tmo_idle");

    // partial command discarded after RX_TIMEOUT
    rsp_mode = 0;
    send_byte(8'h57); send_byte(8'h12);
    gap(RX_TIMEOUT - 10);
    chk("partial_busy", busy, 1);
    gap(20);
    chk("partial_idle", busy, 0);
    chk("partial_noreq", rd_req | wr_req, 0);

    // slow write with byte gaps below RX_TIMEOUT, overrun during WAIT
    rsp_lat = 12;
    txq.push_back(8'h4B);
    cmd_wr(24'hC00007, 16'h55AA, 30);
    gap(2);
    send_byte(8'h42);
    chk("overrun", rx_overrun, 1);
    wait_idle("ovr_idle");
    chk("overrun_sticky", rx_overrun, 1);

    // reset during WAIT
    rsp_mode = 2;
    cmd_wr(24'hFFFFFF, 16'h1234, 0);
    gap(3);
    #2 rst_n = 0;
    #1;
    chk("rst_async", {wr_req, rd_req, busy, tx_start, rx_overrun}, 0);
    gap(2);
    rst_n = 1;
    rsp_mode = 0; rsp_lat = 2;
    gap(2);
    txq.push_back(8'h4B);
    cmd_wr(24'h000000, 16'h0001, 0);
    wait_idle("post_rst_idle");

    gap(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
